uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver: the consumer of the baud generator's oversample tick. It samples a synchronized `rx_i` line at mid-bit using a 16x oversample tick and deframes 8N1 characters (start, DATA_BITS data LSB-first, one stop). It presents each received character on a valid/acknowledge holding register for the host side. It flags framing errors and overruns, and sits between the pin and the UART host/FIFO logic.

## Interface
- `DATA_BITS`, 8: data bits per frame (5–8).
- `OVERSAMPLE`, 16: baud ticks per bit period; must be even, ≥4.
- `clk_i` in 1: system clock; all logic on rising edge.
- `arst_i` in 1: asynchronous, active-high reset.
- `baudTick_i` in 1: one-cycle pulse at OVERSAMPLE × baud rate, from the baud generator.
- `rx_i` in 1: asynchronous serial input, idle high.
- `ack_i` in 1: host read acknowledge; consumes the held character.
- `data_o` out DATA_BITS: last accepted character.
- `dataValid_o` out 1: `data_o` holds an unread character.
- `frameErr_o` out 1: one-cycle pulse when the stop bit samples low.
- `overrun_o` out 1: sticky; a character completed while `dataValid_o` was high.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- Input sync: 2-FF synchronizer on `rx_i`, both flops reset to 1. All FSM decisions use the synchronized value `rxS`.
- Counters:
  - `tickCnt` is log2(OVERSAMPLE) bits wide, advances only on `baudTick_i`, and wraps at OVERSAMPLE-1.
  - `bitCnt` is log2(DATA_BITS)+1 bits wide.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a `baudTick_i` cycle with `rxS`=0, go to START and set `tickCnt`=0.
  - START: on each tick, `tickCnt`++. On the tick where `tickCnt`=OVERSAMPLE/2-1 (mid start bit):
    - if `rxS`=0, go to DATA with `tickCnt`=0 and `bitCnt`=0;
    - otherwise return to IDLE (glitch rejected, no flags).
  - DATA: on the tick where `tickCnt`=OVERSAMPLE-1, shift `rxS` into the MSB of the shift register (right shift, LSB-first line order) and increment `bitCnt`. After DATA_BITS samples, go to STOP with `tickCnt`=0.
  - STOP: on the tick where `tickCnt`=OVERSAMPLE-1, sample `rxS`:
    - `rxS`=1: deliver the character (see below);
    - `rxS`=0: pulse `frameErr_o`; the character is discarded.
    - Either way, return to IDLE. A low stop bit does not arm a new start until `rxS` is observed low on a later tick in IDLE.
- Delivery:
  - If `dataValid_o`=0, or `ack_i`=1 in the same cycle: load `data_o` and set `dataValid_o`=1.
  - Otherwise: set `overrun_o`=1, and leave `data_o` and `dataValid_o` unchanged (new character dropped).
- Acknowledge: `ack_i`=1 clears `dataValid_o` and `overrun_o`, unless a delivery occurs in the same cycle. In that case `dataValid_o` stays 1, the new data loads, and `overrun_o` clears.
- `ack_i` while `dataValid_o`=0 has no effect.
- `baudTick_i` held high continuously is legal: each cycle counts as one tick.

## Timing
- Reset values: state IDLE, counters 0, shift register 0, `data_o`=0, `dataValid_o`=0, `frameErr_o`=0, `overrun_o`=0, `busy_o`=0, sync flops 1.
- Reset mid-frame aborts immediately. No partial data and no flags are produced afterwards.
- Pin-to-FSM latency: 2 clocks.
- Sample points, relative to the detecting tick: start check at tick OVERSAMPLE/2; data bit n at OVERSAMPLE/2 + (n+1)·OVERSAMPLE; stop at OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE.
- `dataValid_o`, `data_o`, `overrun_o` and `frameErr_o` update on the clock edge that processes the stop-sample tick. This is 1 cycle after the tick is presented.
- `frameErr_o` is high for exactly 1 clock.
- Back-to-back frames: a start edge is detectable on the first tick after STOP returns to IDLE, which is half a bit before the nominal stop end.

## Test plan
- Normal frame: OVERSAMPLE=16 with a tick every 4 clocks; send 0xA5 8N1 -> `dataValid_o`=1 and `data_o`=0xA5 one cycle after the stop-sample tick; `frameErr_o`=0 and `overrun_o`=0 throughout.
- Glitch rejection: drive `rx_i` low for 4 ticks, then high -> FSM returns to IDLE at start-check tick 8; no `dataValid_o` and no `frameErr_o`; `busy_o` falls.
- Framing error: send 0x3C with stop bit 0 -> single-cycle `frameErr_o`; `dataValid_o` stays 0; `data_o` is unchanged from its prior value.
- Overrun: receive 0x11 without ack, then 0x22 -> `overrun_o`=1 and `data_o`=0x11. A subsequent `ack_i` -> `dataValid_o`=0 and `overrun_o`=0.
- Simultaneous ack and delivery: hold 0x11, then assert `ack_i` on the cycle 0x22 completes -> `data_o`=0x22, `dataValid_o`=1, `overrun_o`=0.
- Reset mid-frame: assert `arst_i` during data bit 3 of 0xFF, release it, then send 0x5A -> all outputs at reset values after reset; only 0x5A is delivered.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x-oversampled mid-bit sampling with a valid/ack holding register.
// Flags framing errors (one-cycle pulse) and overruns (sticky until acknowledged).
//
// state | meaning
// IDLE  | line idle, waiting for a low sample on a baud tick
// START | counting to mid start bit to confirm the start edge
// DATA  | sampling DATA_BITS data bits at mid-bit, LSB first
// STOP  | sampling the stop bit, then deliver or flag framing error
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 baudTick_i,
    input  logic                 rx_i,
    input  logic                 ack_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 dataValid_o,
    output logic                 frameErr_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, stateNext;
    logic                 rxMeta, rxS;
    logic [TW-1:0]        tickCnt, tickCntNext;
    logic [BW-1:0]        bitCnt, bitCntNext;
    logic [DATA_BITS-1:0] shiftReg, shiftRegNext;
    logic                 deliver, stopBad;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rx_i;
            rxS    <= rxMeta;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            tickCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            tickCnt  <= tickCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftRegNext;
        end
    end

    always_comb begin
        stateNext    = state;
        tickCntNext  = tickCnt;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        deliver      = 1'b0;
        stopBad      = 1'b0;
        unique case (state)
            IDLE: begin
                if (baudTick_i && !rxS) begin
                    stateNext   = START;
                    tickCntNext = '0;
                end
            end
            START: begin
                if (baudTick_i) begin
                    if (tickCnt == TICK_MID) begin
                        if (!rxS) begin
                            stateNext   = DATA;
                            tickCntNext = '0;
                            bitCntNext  = '0;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        tickCntNext = tickCnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (baudTick_i) begin
                    if (tickCnt == TICK_LAST) begin
                        tickCntNext  = '0;
                        shiftRegNext = {rxS, shiftReg[DATA_BITS-1:1]};
                        bitCntNext   = bitCnt + BW'(1);
                        if (bitCnt == BIT_LAST) begin
                            stateNext = STOP;
                        end
                    end else begin
                        tickCntNext = tickCnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (baudTick_i) begin
                    if (tickCnt == TICK_LAST) begin
                        stateNext   = IDLE;
                        tickCntNext = '0;
                        deliver     = rxS;
                        stopBad     = !rxS;
                    end else begin
                        tickCntNext = tickCnt + TW'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // A delivery coinciding with ack replaces the held character and clears overrun.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o      <= '0;
            dataValid_o <= 1'b0;
            frameErr_o  <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frameErr_o <= stopBad;
            if (deliver) begin
                if (!dataValid_o || ack_i) begin
                    data_o      <= shiftReg;
                    dataValid_o <= 1'b1;
                    if (ack_i) begin
                        overrun_o <= 1'b0;
                    end
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (ack_i && dataValid_o) begin
                dataValid_o <= 1'b0;
                overrun_o   <= 1'b0;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, the expected holding-register
// outcome and its clock edge are queued at frame start and checked by an independent monitor.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DB = 8;

    typedef struct {
        int         kind;   // 0 deliver, 1 framing error, 2 overrun
        logic [7:0] d;
        int         edgeNo;
        logic       expV;
        logic [7:0] held;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst, baudTick, rx, ack, contTick;
    logic [7:0] data;
    logic       dataValid, frameErr, overrun, busy;

    int   checks = 0;
    int   failures = 0;
    int   edgeCnt = 0;
    exp_t expQ[$];

    logic       mValid = 1'b0;
    logic [7:0] mData = 8'h00;
    logic       mOverrun = 1'b0;

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .baudTick_i  (baudTick),
        .rx_i        (rx),
        .ack_i       (ack),
        .data_o      (data),
        .dataValid_o (dataValid),
        .frameErr_o  (frameErr),
        .overrun_o   (overrun),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    initial begin
        int div;
        div = 0;
        baudTick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            baudTick = contTick || (div == 0);
        end
    end

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, expv, edgeCnt);
        end
    endfunction

    // Monitor: any visible change of the holding register or a flag consumes one expectation.
    logic       prevV = 1'b0, prevO = 1'b0, prevFe = 1'b0;
    logic [7:0] prevD = 8'h00;
    exp_t       e;
    always @(negedge clk) begin
        if (arst) begin
            prevV = 1'b0; prevO = 1'b0; prevFe = 1'b0; prevD = 8'h00;
        end else begin
            if (frameErr) chk("frameErr_single_cycle", int'(prevFe), 0);
            if (frameErr || (dataValid && !prevV) || (overrun && !prevO) ||
                (dataValid && prevV && data != prevD)) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output valid=%0b data=%0h ferr=%0b ovr=%0b edge=%0d",
                             dataValid, data, frameErr, overrun, edgeCnt);
                end else begin
                    e = expQ.pop_front();
                    chk("event_edge", edgeCnt, e.edgeNo);
                    case (e.kind)
                        0: begin
                            chk("deliver_valid", int'(dataValid), 1);
                            chk("deliver_data", int'(data), int'(e.d));
                            chk("deliver_ferr", int'(frameErr), 0);
                            chk("deliver_overrun", int'(overrun), 0);
                        end
                        1: begin
                            chk("ferr_pulse", int'(frameErr), 1);
                            chk("ferr_valid", int'(dataValid), int'(e.expV));
                            chk("ferr_data_kept", int'(data), int'(e.held));
                        end
                        default: begin
                            chk("overrun_flag", int'(overrun), 1);
                            chk("overrun_valid", int'(dataValid), 1);
                            chk("overrun_data_kept", int'(data), int'(e.held));
                            chk("overrun_ferr", int'(frameErr), 0);
                        end
                    endcase
                end
            end
            prevV = dataValid; prevO = overrun; prevFe = frameErr; prevD = data;
        end
    end

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_data"}, int'(data), 0);
        chk({tag, "_valid"}, int'(dataValid), 0);
        chk({tag, "_ferr"}, int'(frameErr), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_tick_edge(output int pt);
        do @(posedge clk); while (!baudTick);
        @(negedge clk);
        pt = edgeCnt;
    endtask

    // Sends start + 8 data (LSB first) + stop. The expected result lands on the edge of the
    // stop-sample tick: detecting tick + OS/2 + (DB+1)*OS ticks.
    task automatic send_frame(input logic [7:0] d, input bit stopBit, input bit ackAtEnd,
                              input int abortAt);
        int         T, pt, det, expEdge, bitLen;
        logic [9:0] bits;
        exp_t       x;
        T      = contTick ? 1 : 4;
        bitLen = OS * T;
        bits   = {stopBit, d, 1'b0};
        wait_tick_edge(pt);
        det     = pt + T * ((3 + T - 1) / T);
        expEdge = det + T * (OS / 2 + (DB + 1) * OS);
        if (abortAt == 0) begin
            x.d = d; x.edgeNo = expEdge; x.held = mData; x.expV = mValid;
            if (!stopBit) begin
                if (ackAtEnd) begin
                    mValid = 1'b0;
                    mOverrun = 1'b0;
                end
                x.kind = 1; x.expV = mValid;
                expQ.push_back(x);
            end else if (!mValid || ackAtEnd) begin
                x.kind = 0;
                expQ.push_back(x);
                mValid = 1'b1; mData = d; mOverrun = 1'b0;
            end else if (!mOverrun) begin
                x.kind = 2;
                expQ.push_back(x);
                mOverrun = 1'b1;
            end
        end
        for (int c = 0; c < 10 * bitLen; c++) begin
            if (abortAt > 0 && c == abortAt) begin
                arst = 1'b1; rx = 1'b1; ack = 1'b0;
                @(negedge clk);
                chk_reset_outputs("midframe_reset");
                @(negedge clk);
                arst = 1'b0;
                mValid = 1'b0; mData = 8'h00; mOverrun = 1'b0;
                return;
            end
            rx  = bits[c / bitLen];
            ack = ackAtEnd && (edgeCnt + 1 == expEdge);
            @(negedge clk);
        end
        rx = 1'b1;
        ack = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        mValid = 1'b0;
        mOverrun = 1'b0;
        chk("after_ack_valid", int'(dataValid), 0);
        chk("after_ack_overrun", int'(overrun), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at edge %0d", edgeCnt);
        $fatal(1, "timeout");
    end

    initial begin
        int pt;
        logic [7:0] d;
        arst = 1'b1; rx = 1'b1; ack = 1'b0; contTick = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        arst = 1'b0;
        repeat (10) @(negedge clk);

        // Normal frame
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        repeat (8) @(negedge clk);
        do_ack();

        // Glitch: low for 4 ticks only
        wait_tick_edge(pt);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_high", int'(busy), 1);
        repeat (24) @(negedge clk);
        chk("glitch_busy_low", int'(busy), 0);
        chk("glitch_no_valid", int'(dataValid), 0);

        // Framing error leaves data_o at 0xA5
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        repeat (8) @(negedge clk);

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        repeat (8) @(negedge clk);
        do_ack();

        // Ack coinciding with delivery
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b1, 0);
        repeat (8) @(negedge clk);
        chk("simul_valid", int'(dataValid), 1);
        chk("simul_data", int'(data), 8'h22);
        do_ack();

        // Reset during data bit 3 of 0xFF, then a clean frame
        send_frame(8'hFF, 1'b1, 1'b0, (1 + 3) * OS * 4 + OS * 2);
        repeat (OS * 4 * 12) @(negedge clk);
        chk_reset_outputs("post_reset_idle");
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        repeat (8) @(negedge clk);
        do_ack();

        // Tick held high continuously
        contTick = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0, 0);
        contTick = 1'b0;
        repeat (8) @(negedge clk);
        do_ack();

        // Random frames with random stop bits and host behaviour
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            send_frame(d, ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0), 0);
            repeat (4) @(negedge clk);
            if ($urandom_range(0, 3) != 0) do_ack();
        end

        repeat (50) @(negedge clk);
        chk("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
